// File: rtl/chan_event_counter.sv
// Multi-channel change-event counter with a registered read port,
// read-and-clear, wrap/saturate counting and sticky overflow flags.

// One channel: change detector, counter and sticky overflow flag.
module chan_event_lane #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ev_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             ovf_o,
    output logic             chg_o
);
    logic             prev_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    assign chg_o = ev_i ^ prev_q;
    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

    // Previous level tracks the input on every edge, reset included, so the
    // first edge after release never sees a stale level.
    always_ff @(posedge clk) begin
        prev_q <= ev_i;
    end

    // Next count: a clear restarts from the coincident event so it is not lost.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = chg_o ? WIDTH'(1) : '0;
            ovf_d = 1'b0;
        end else if (chg_o) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
                cnt_d = (SATURATE != 0) ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    // Count and overflow state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

module chan_event_counter #(
    parameter int   NCHAN    = 4,
    parameter int   WIDTH    = 8,
    parameter int   SATURATE = 0,
    localparam int  CHW      = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCHAN-1:0] ev_in,
    input  logic             rd_req,
    input  logic [CHW-1:0]   rd_chan,
    input  logic             rd_clear,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_ovf,
    output logic             rd_err,
    output logic             any_event,
    output logic [NCHAN-1:0] ovf_flags
);
    logic [NCHAN-1:0][WIDTH-1:0] cnt;
    logic [NCHAN-1:0]            ovf;
    logic [NCHAN-1:0]            chg;
    logic [NCHAN-1:0]            clr;

    logic [WIDTH-1:0] sel_cnt;
    logic             sel_ovf;
    logic             sel_ok;

    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_ovf_q, rd_ovf_d;
    logic             rd_err_q, rd_err_d;
    logic             any_event_q, any_event_d;

    genvar i;
    generate
        for (i = 0; i < NCHAN; i++) begin : g_lane
            assign clr[i] = rd_req & rd_clear & (rd_chan == CHW'(i));
            chan_event_lane #(
                .WIDTH    (WIDTH),
                .SATURATE (SATURATE)
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .ev_i  (ev_in[i]),
                .clr_i (clr[i]),
                .cnt_o (cnt[i]),
                .ovf_o (ovf[i]),
                .chg_o (chg[i])
            );
        end
    endgenerate

    // Read mux; an out-of-range channel matches no lane and yields zeros.
    always_comb begin
        sel_cnt = '0;
        sel_ovf = 1'b0;
        sel_ok  = 1'b0;
        for (int c = 0; c < NCHAN; c++) begin
            if (rd_chan == CHW'(c)) begin
                sel_cnt = cnt[c];
                sel_ovf = ovf[c];
                sel_ok  = 1'b1;
            end
        end
    end

    // Snapshot is taken from pre-edge state, so the coincident increment is excluded.
    always_comb begin
        rd_valid_d  = rd_req;
        rd_data_d   = rd_req ? sel_cnt : rd_data_q;
        rd_ovf_d    = rd_req ? sel_ovf : rd_ovf_q;
        rd_err_d    = rd_req ? ~sel_ok : rd_err_q;
        any_event_d = |chg;
    end

    // Registered read port and event summary; reset overrides a same-edge read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_ovf_q    <= 1'b0;
            rd_err_q    <= 1'b0;
            any_event_q <= 1'b0;
        end else begin
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_ovf_q    <= rd_ovf_d;
            rd_err_q    <= rd_err_d;
            any_event_q <= any_event_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_ovf    = rd_ovf_q;
    assign rd_err    = rd_err_q;
    assign any_event = any_event_q;
    assign ovf_flags = ovf;
endmodule

// File: doc/chan_event_counter.md
# chan_event_counter

Multi-channel change-event counter: samples NCHAN single-bit inputs each clock, detects any value change (either direction) per channel, and accumulates a WIDTH-bit count per channel. Provides a registered read port with optional read-and-clear, wrap or saturate modes, and sticky per-channel overflow flags. Sits alongside the mixed-language regression benches as a synthesizable, clocked, parametrised generalisation of the single-channel "count every change of y" behaviour, with explicit snapshot-versus-update ordering.

## Interface
- NCHAN, 4: number of monitored channels, 1..64
- WIDTH, 8: counter width per channel, 2..32
- SATURATE, 0: 0 = counters wrap at 2^WIDTH, 1 = counters hold at 2^WIDTH-1
- CHW, $clog2(NCHAN) (minimum 1): width of rd_chan; derived, not overridden

- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  reset, synchronous, active-high
- ev_in  input  NCHAN  monitored channel levels, synchronous to clk
- rd_req  input  1  read request, sampled at posedge
- rd_chan  input  CHW  channel to read
- rd_clear  input  1  clear the channel's count and overflow flag as part of the read
- rd_valid  output  1  one-cycle pulse: rd_data/rd_ovf/rd_err valid
- rd_data  output  WIDTH  count snapshot of the requested channel
- rd_ovf  output  1  overflow flag snapshot of the requested channel
- rd_err  output  1  rd_chan >= NCHAN
- any_event  output  1  registered OR of all channel changes detected at the last edge
- ovf_flags  output  NCHAN  live sticky overflow flags

## Operation
- Change detect: prev[i] holds ev_in[i] from the previous edge; change[i] = ev_in[i] ^ prev[i]. prev updates every edge, including during rst.
- Reset (rst=1 at an edge): all counts 0, all overflow flags 0, rd_valid/rd_data/rd_ovf/rd_err/any_event 0, prev <= ev_in. No change is counted for the edge where rst is sampled high, nor spuriously for the first edge after release.
- Increment: at each edge with change[i]=1, count[i] <= count[i]+1. In wrap mode, all-ones +1 -> 0 and ovf[i] <= 1. In saturate mode, all-ones stays all-ones and ovf[i] <= 1. ovf is sticky until rst or read-and-clear of that channel.
- Read: rd_req=1 at edge k with valid rd_chan -> rd_data/rd_ovf capture count/ovf as held before edge k (the edge-k increment is excluded from the snapshot).
- Read-and-clear (rd_clear=1): at edge k, count[c] <= (change[c] ? 1 : 0), ovf[c] <= 0. An event coincident with the clear is never lost: it appears in the next read. rd_clear is ignored when rd_req=0.
- Invalid channel (rd_chan >= NCHAN, only possible when NCHAN is not a power of 2): rd_valid=1, rd_err=1, rd_data=0, rd_ovf=0, no state change.
- Back-to-back reads every cycle are supported; no busy/ready, rd_req is always accepted.

## Timing
- Increment latency: ev_in change presented before edge k is counted at edge k; visible in count and ovf_flags immediately after edge k.
- Read latency: 1 cycle. rd_req at edge k -> rd_valid high for the cycle following edge k, low otherwise (it is a pulse, not held).
- any_event is registered: high for the cycle after any edge where any change[i]=1.
- rst mid-read: rst at edge k overrides a read sampled at edge k; rd_valid stays 0.
- Multiple channels changing at the same edge all increment at that edge.

## Test plan
- Reset/no-spurious: hold ev_in=4'b1010 through rst, release -> after 3 idle cycles a read of each channel returns 0, rd_ovf=0, any_event never high.
- Toggle counting: toggle ch2 on 5 consecutive edges (ch0 static) -> read ch2 returns 5, read ch0 returns 0; any_event high for exactly 5 cycles.
- Snapshot ordering: ch1 count 3, toggle ch1 and issue rd_req ch1 rd_clear=1 at the same edge -> rd_data=3; next read of ch1 returns 1.
- Wrap vs saturate (WIDTH=2): 5 toggles on ch0 -> SATURATE=0 reads 1 with rd_ovf=1; SATURATE=1 reads 3 with rd_ovf=1; read-and-clear then read again -> 0, rd_ovf=0, ovf_flags[0]=0.
- Invalid channel (NCHAN=3): rd_req rd_chan=3 rd_clear=1 -> rd_valid=1, rd_err=1, rd_data=0; counts of ch0..2 unchanged.
- Reset mid-operation: counts non-zero, assert rst at the same edge as rd_req -> rd_valid stays 0; all counts and ovf_flags read back 0 afterwards.
